// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI TMDS 8b/10b encoder with per-channel running disparity.
// Define TMDS_GUARD_BAND_EN to add a third stage that inserts video guard bands.
module tmds_encoder_3ch #(
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] in_color,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_blank,
    output logic [9:0]  out_red,
    output logic [9:0]  out_green,
    output logic [9:0]  out_blue,
    output logic        out_de
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef logic signed [CNT_W-1:0] disp_t;

    localparam disp_t DISP_ZERO  = '0;
    localparam disp_t DISP_TWO   = disp_t'(2);
    localparam disp_t DISP_EIGHT = disp_t'(8);

    typedef struct packed {
        logic [9:0] sym;
        disp_t      delta;
    } enc_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctrl);
        logic [9:0] s;
        case (ctrl)
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            2'b11:   s = CTRL_11;
            default: s = CTRL_00;
        endcase
        return s;
    endfunction

    // Transition minimisation: XNOR chain when the byte is ones-heavy, q_m[8] flags XOR.
    function automatic logic [8:0] minimize(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = q[i-1] ^ d[i] ^ use_xnor;
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // diff = n1 - n0 = 2*n1 - 8; the symbol choice steers cnt back towards zero.
    function automatic enc_t balance(input logic [8:0] qm, input logic [3:0] n1,
                                     input disp_t cnt);
        disp_t diff;
        enc_t  r;
        diff = disp_t'({n1, 1'b0}) - DISP_EIGHT;
        if ((cnt == DISP_ZERO) || (diff == DISP_ZERO)) begin
            r.sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            r.delta = qm[8] ? diff : -diff;
        end else if (((cnt > DISP_ZERO) && (diff > DISP_ZERO)) ||
                     ((cnt < DISP_ZERO) && (diff < DISP_ZERO))) begin
            r.sym   = {1'b1, qm[8], ~qm[7:0]};
            r.delta = (qm[8] ? DISP_TWO : DISP_ZERO) - diff;
        end else begin
            r.sym   = {1'b0, qm[8], qm[7:0]};
            r.delta = diff - (qm[8] ? DISP_ZERO : DISP_TWO);
        end
        return r;
    endfunction

    // Channel index: 0 = blue, 1 = green, 2 = red.
    logic [7:0] ch_data [3];
    assign ch_data[0] = in_color[7:0];
    assign ch_data[1] = in_color[15:8];
    assign ch_data[2] = in_color[23:16];

    logic [8:0] qm_next   [3];
    logic [3:0] ones_next [3];
    logic [8:0] s1_qm     [3];
    logic [3:0] s1_ones   [3];
    logic       s1_blank;
    logic [1:0] s1_sync;

    disp_t      cnt       [3];
    enc_t       enc       [3];
    logic [9:0] s2_sym    [3];
    logic       s2_blank;

    // NOTE: always_comb uses blocking assignments and assigns every output on
    // every pass, so no latch is inferred; clocked state below uses <= only.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            qm_next[c]   = minimize(ch_data[c]);
            ones_next[c] = ones8(qm_next[c][7:0]);
            enc[c]       = balance(s1_qm[c], s1_ones[c], cnt[c]);
        end
    end

    // NOTE: reset is synchronous; every pipeline register, including the small
    // per-channel arrays, is cleared so the first symbols out are control 00.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < 3; c++) begin
                s1_qm[c]   <= '0;
                s1_ones[c] <= '0;
                cnt[c]     <= DISP_ZERO;
                s2_sym[c]  <= CTRL_00;
            end
            s1_blank <= 1'b1;
            s1_sync  <= 2'b00;
            s2_blank <= 1'b1;
        end else begin
            for (int c = 0; c < 3; c++) begin
                s1_qm[c]   <= qm_next[c];
                s1_ones[c] <= ones_next[c];
                if (s1_blank) begin
                    cnt[c]    <= DISP_ZERO;
                    s2_sym[c] <= (c == 0) ? ctrl_symbol(s1_sync) : CTRL_00;
                end else begin
                    cnt[c]    <= cnt[c] + enc[c].delta;
                    s2_sym[c] <= enc[c].sym;
                end
            end
            s1_blank <= in_blank;
            s1_sync  <= {in_vsync, in_hsync};
            s2_blank <= s1_blank;
        end
    end

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [9:0] GB_BLUE_RED = 10'b1011001100;
    localparam logic [9:0] GB_GREEN    = 10'b0100110011;

    logic [9:0] s3_sym [3];
    logic       s3_de;
    logic       guard;

    // Stage 1 and the live input are the two symbols following stage 2, so a
    // blanked stage-2 symbol within two of the next active pixel is a guard band.
    assign guard = s2_blank && (!s1_blank || !in_blank);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < 3; c++) begin
                s3_sym[c] <= CTRL_00;
            end
            s3_de <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (guard) begin
                    s3_sym[c] <= (c == 1) ? GB_GREEN : GB_BLUE_RED;
                end else begin
                    s3_sym[c] <= s2_sym[c];
                end
            end
            s3_de <= ~s2_blank;
        end
    end

    assign out_blue  = s3_sym[0];
    assign out_green = s3_sym[1];
    assign out_red   = s3_sym[2];
    assign out_de    = s3_de;
`else
    assign out_blue  = s2_sym[0];
    assign out_green = s2_sym[1];
    assign out_red   = s2_sym[2];
    assign out_de    = ~s2_blank;
`endif

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Self-checking bench for tmds_encoder_3ch: cycle model + symbol decoder + directed literals.
// Follows TMDS_GUARD_BAND_EN for latency and guard-band expectations.
module tb_tmds_encoder_3ch;

`ifdef TMDS_GUARD_BAND_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [9:0] CTRL00 = 10'b1101010100;
    localparam logic [9:0] CTRL01 = 10'b0010101011;
    localparam logic [9:0] CTRL10 = 10'b0101010100;
    localparam logic [9:0] CTRL11 = 10'b1010101011;
    localparam logic [9:0] GB_BR  = 10'b1011001100;
    localparam logic [9:0] GB_G   = 10'b0100110011;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] in_color = '0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_blank = 1'b1;
    logic [9:0]  out_red;
    logic [9:0]  out_green;
    logic [9:0]  out_blue;
    logic        out_de;

    always #5 clk = ~clk;

    tmds_encoder_3ch #(.CNT_W(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_color  (in_color),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_blank  (in_blank),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .out_de    (out_de)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [9:0] ref_encode(input logic [7:0] d, input int cnt_in,
                                              output int cnt_out);
        int         n1d, n1, n0;
        logic       xn, q8;
        logic [7:0] q;
        logic [9:0] s;
        n1d  = $countones(d);
        xn   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q8 = ~xn;
        n1 = $countones(q);
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0) begin
            s       = {~q8, q8, q8 ? q : ~q};
            cnt_out = cnt_in + (q8 ? (n1 - n0) : (n0 - n1));
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            s       = {1'b1, q8, ~q};
            cnt_out = cnt_in + 2 * int'(q8) + n0 - n1;
        end else begin
            s       = {1'b0, q8, q};
            cnt_out = cnt_in + n1 - n0 - 2 * int'(!q8);
        end
        return s;
    endfunction

    // Receiver-side decode: recovers the pixel byte from an active symbol.
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    typedef struct packed {
        logic        blank;
        logic [23:0] color;
        logic [9:0]  sr;
        logic [9:0]  sg;
        logic [9:0]  sb;
    } rec_t;

    localparam rec_t IDLE = '{blank: 1'b1, color: 24'h0, sr: CTRL00, sg: CTRL00, sb: CTRL00};

    rec_t pipe [3];
    int   m_cnt [3];
    rec_t exp_r;
    logic exp_valid = 1'b0;

    initial begin
        logic [9:0] ctrl_tab [4];
        ctrl_tab[0] = CTRL00;
        ctrl_tab[1] = CTRL01;
        ctrl_tab[2] = CTRL10;
        ctrl_tab[3] = CTRL11;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                for (int k = 0; k < 3; k++) begin
                    pipe[k]  = IDLE;
                    m_cnt[k] = 0;
                end
            end else begin
                rec_t r;
                int   nc;
                r.blank = in_blank;
                r.color = in_color;
                if (in_blank) begin
                    r.sb = ctrl_tab[{in_vsync, in_hsync}];
                    r.sg = CTRL00;
                    r.sr = CTRL00;
                    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
                end else begin
                    r.sb = ref_encode(in_color[7:0],   m_cnt[0], nc); m_cnt[0] = nc;
                    r.sg = ref_encode(in_color[15:8],  m_cnt[1], nc); m_cnt[1] = nc;
                    r.sr = ref_encode(in_color[23:16], m_cnt[2], nc); m_cnt[2] = nc;
                end
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = r;
            end
            exp_r = pipe[LAT-1];
`ifdef TMDS_GUARD_BAND_EN
            if (pipe[2].blank && (!pipe[1].blank || !pipe[0].blank)) begin
                exp_r.sb = GB_BR;
                exp_r.sg = GB_G;
                exp_r.sr = GB_BR;
            end
`endif
            exp_valid = 1'b1;
        end
    end

    // Compare process: every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                check("model blue",  {22'b0, out_blue},  {22'b0, exp_r.sb});
                check("model green", {22'b0, out_green}, {22'b0, exp_r.sg});
                check("model red",   {22'b0, out_red},   {22'b0, exp_r.sr});
                check("model de",    {31'b0, out_de},    {31'b0, ~exp_r.blank});
                if (!exp_r.blank) begin
                    check("decode blue",  {24'b0, decode(out_blue)},  {24'b0, exp_r.color[7:0]});
                    check("decode green", {24'b0, decode(out_green)}, {24'b0, exp_r.color[15:8]});
                    check("decode red",   {24'b0, decode(out_red)},   {24'b0, exp_r.color[23:16]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic        blank;
        logic        vs;
        logic        hs;
        logic [23:0] color;
        logic        lit;
        logic [9:0]  lb;
        logic [9:0]  lg;
        logic [9:0]  lr;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic b, input logic vs, input logic hs, input logic [23:0] col,
                       input logic lit, input logic [9:0] lb, input logic [9:0] lg,
                       input logic [9:0] lr);
        vec_t v;
        v = '{blank: b, vs: vs, hs: hs, color: col, lit: lit, lb: lb, lg: lg, lr: lr};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic b, input logic vs, input logic hs, input logic [23:0] col);
        in_blank = b;
        in_vsync = vs;
        in_hsync = hs;
        in_color = col;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string tag, input logic [9:0] lb, input logic [9:0] lg,
                             input logic [9:0] lr, input logic de);
        check({tag, " blue"},  {22'b0, out_blue},  {22'b0, lb});
        check({tag, " green"}, {22'b0, out_green}, {22'b0, lg});
        check({tag, " red"},   {22'b0, out_red},   {22'b0, lr});
        check({tag, " de"},    {31'b0, out_de},    {31'b0, de});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pb, pg, pr, pb16;
`ifdef TMDS_GUARD_BAND_EN
        pb = GB_BR; pg = GB_G; pr = GB_BR; pb16 = GB_BR;
`else
        pb = CTRL00; pg = CTRL00; pr = CTRL00; pb16 = CTRL01;
`endif
        add(1, 0, 1, 24'h000000, 1, CTRL01, CTRL00, CTRL00);
        add(1, 1, 0, 24'h000000, 1, CTRL10, CTRL00, CTRL00);
        add(1, 1, 1, 24'h000000, 1, CTRL11, CTRL00, CTRL00);
        add(1, 0, 0, 24'h000000, 1, CTRL00, CTRL00, CTRL00);
        add(1, 0, 0, 24'h000000, 1, pb, pg, pr);
        add(1, 0, 0, 24'h000000, 1, pb, pg, pr);
        add(0, 0, 0, 24'h000000, 1, 10'b0100000000, 10'b0100000000, 10'b0100000000);
        add(0, 0, 0, 24'h000000, 1, 10'b1111111111, 10'b1111111111, 10'b1111111111);
        add(1, 0, 0, 24'h000000, 0, CTRL00, CTRL00, CTRL00);
        add(1, 0, 0, 24'h000000, 1, pb, pg, pr);
        add(1, 0, 0, 24'h000000, 1, pb, pg, pr);
        add(0, 0, 0, 24'hFFFFFF, 1, 10'b1000000000, 10'b1000000000, 10'b1000000000);
        add(0, 0, 0, 24'hFFFFFF, 1, 10'b0011111111, 10'b0011111111, 10'b0011111111);
        add(0, 1, 1, 24'h000000, 1, 10'b1111111111, 10'b1111111111, 10'b1111111111);
        add(1, 0, 0, 24'h000000, 1, pb, pg, pr);
        add(0, 0, 0, 24'h000000, 1, 10'b0100000000, 10'b0100000000, 10'b0100000000);
        add(1, 0, 1, 24'h000000, 1, pb16, pg, pr);
        add(0, 0, 0, 24'h000000, 1, 10'b0100000000, 10'b0100000000, 10'b0100000000);
        add(1, 0, 0, 24'h000000, 1, CTRL00, CTRL00, CTRL00);

        // Reset with hsync high still yields control 00 everywhere.
        resetn = 1'b0;
        repeat (3) drive(1, 0, 1, 24'h0);
        check_lit("reset", CTRL00, CTRL00, CTRL00, 1'b0);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size() + LAT - 1; i++) begin
            int j;
            if (i < tbl.size()) drive(tbl[i].blank, tbl[i].vs, tbl[i].hs, tbl[i].color);
            else                drive(1, 0, 0, 24'h0);
            j = i - (LAT - 1);
            if (j >= 0 && tbl[j].lit) begin
                check_lit($sformatf("vec%0d", j), tbl[j].lb, tbl[j].lg, tbl[j].lr, ~tbl[j].blank);
            end
        end

        // Random traffic with short blank runs and sync toggling during video.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 24'($urandom));
        end

        // Reset mid-line, then the first active pixel restarts from zero disparity.
        repeat (5) drive(0, 0, 0, 24'($urandom));
        resetn = 1'b0;
        drive(0, 0, 0, 24'h123456);
        check_lit("mid reset", CTRL00, CTRL00, CTRL00, 1'b0);
        resetn = 1'b1;
        drive(0, 0, 0, 24'h000000);
        for (int k = 0; k < LAT - 1; k++) drive(0, 0, 0, 24'h000000);
        check_lit("post reset", 10'b0100000000, 10'b0100000000, 10'b0100000000, 1'b1);

        repeat (4) drive(1, 0, 0, 24'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_3ch.md
Name:
tmds_encoder_3ch

Overview:
- Three-channel TMDS 8b/10b encoder directly downstream of the VGA pixel generator.
- Consumes the registered 24-bit colour, hsync, vsync and blank, all in the pixel-clock domain.
- Produces one 10-bit DVI symbol per channel per pixel clock for the external 10:1 serializer / fake-differential output stage.
- Running disparity is tracked per channel so the link stays DC-balanced.

Parameters:
- CNT_W, 5, width of each signed running-disparity counter; must be >= 5.

Ports:
- clk  in  1  pixel clock
- resetn  in  1  synchronous active-low reset
- in_color  in  24  {R[23:16], G[15:8], B[7:0]}
- in_hsync  in  1  horizontal sync, carried on blue control bit C0
- in_vsync  in  1  vertical sync, carried on blue control bit C1
- in_blank  in  1  1 = control period, 0 = active video
- out_red  out  10  channel 2 symbol, bit 0 transmitted first
- out_green  out  10  channel 1 symbol
- out_blue  out  10  channel 0 symbol
- out_de  out  1  in_blank delayed and inverted, aligned with the symbols

Behaviour:
- Clock and reset: clk, resetn synchronous active-low (already decided).
- Reset values:
  - all out_* symbols = 10'b1101010100 (control 00)
  - out_de = 0
  - all disparity counters = 0
  - all pipeline registers cleared as blanked, ctrl 00
- Pipeline: 2 register stages, latency 2 clk from inputs to symbols. No stalls, no handshake; one symbol per clk unconditionally.
- Stage 1 (per channel), from d[7:0]:
  - n1d = popcount(d).
  - If n1d > 4, or n1d == 4 and d[0] == 0: XNOR chain, q_m[0] = d[0], q_m[i] = q_m[i-1] XNOR d[i], q_m[8] = 0.
  - Otherwise XOR chain, q_m[8] = 1.
  - Register q_m, ones(q_m[7:0]), blank, ctrl.
- Stage 2 (per channel), n1 = ones(q_m[7:0]), n0 = 8 - n1, cnt signed CNT_W bits:
  - cnt == 0 or n1 == n0: sym = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m8 ? (n1 - n0) : (n0 - n1).
  - (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1): sym = {1, q_m8, ~q_m[7:0]}. cnt += 2*q_m8 + n0 - n1.
  - Else: sym = {0, q_m8, q_m[7:0]}. cnt += n1 - n0 - 2*(~q_m8).
- Blank (stage-2 blank = 1):
  - Emit control symbol by ctrl = {C1, C0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - Blue ctrl = {vsync, hsync}; green and red ctrl = 00.
  - cnt forced to 0.
- Arithmetic: all disparity math is signed CNT_W bits. With CNT_W = 5 the range is -8..+8 and never wraps.
- Boundaries:
  - First active pixel after blank always starts at cnt = 0.
  - blank toggling every clk is legal; each cycle is encoded independently.
  - Reset asserted mid-line: symbols become control 00 on the next edge and disparity clears.
  - Sync changes during active video are ignored; they only take effect when blank = 1.

Optional Feature:
- Macro TMDS_GUARD_BAND_EN. With it defined:
  - A third output register stage is added; latency becomes 3 clk.
  - The 2 symbols immediately preceding each blank 1 -> 0 transition are replaced by video guard bands: blue 1011001100, green 0100110011, red 1011001100.
  - Disparity is unaffected.
  - A blank run shorter than 2 clk is fully replaced.
- Without it: latency 2, no guard bands, plain DVI output.

Test Plan:
- Reset -> all three outputs 1101010100, out_de = 0; release resetn with blank = 1, hsync = 1, vsync = 0 -> blue 0010101011, green/red 1101010100 after 2 clk.
- blank = 1 then active pixel 0x000000, 0x000000 -> each channel emits 0100000000 then 1111111111; cnt -8 then +2.
- blank = 1 then active pixel 0xFFFFFF -> each channel emits 1000000000; cnt = -8.
- Random 10k active pixels -> reference-model decode recovers in_color exactly; |cnt| <= 8 throughout; out_de matches in_blank delayed 2.
- Reset pulsed during active run -> next symbol 1101010100, following first active pixel encoded from cnt = 0.
- TMDS_GUARD_BAND_EN, blank 1 -> 0 at cycle t -> outputs at t+1, t+2 are guard bands (blue 1011001100, green 0100110011), first data symbol at t+3.
